// File: rtl/vid_pkg.sv
// Shared video timing package: mode enum, per-mode horizontal event
// positions and the mode-priority decode. Also used by the vertical generator.
package vid_pkg;

    typedef enum logic [1:0] {
        VM_PAL  = 2'd0,
        VM_NTSC = 2'd1,
        VM_MONO = 2'd2
    } vmode_t;

    // Horizontal event positions in 2 MHz slots (8 bits so LEN=128 fits).
    localparam logic [7:0] PAL_LEN      = 8'd128;
    localparam logic [7:0] PAL_HDE_ON   = 8'd14;
    localparam logic [7:0] PAL_HDE_OFF  = 8'd93;
    localparam logic [7:0] PAL_HBL_ON   = 8'd113;
    localparam logic [7:0] PAL_HBL_OFF  = 8'd23;
    localparam logic [7:0] PAL_HS_ON    = 8'd118;
    localparam logic [7:0] PAL_HS_OFF   = 8'd127;

    localparam logic [7:0] NTSC_LEN     = 8'd127;
    localparam logic [7:0] NTSC_HDE_ON  = 8'd13;
    localparam logic [7:0] NTSC_HDE_OFF = 8'd92;
    localparam logic [7:0] NTSC_HBL_ON  = 8'd112;
    localparam logic [7:0] NTSC_HBL_OFF = 8'd23;
    localparam logic [7:0] NTSC_HS_ON   = 8'd117;
    localparam logic [7:0] NTSC_HS_OFF  = 8'd126;

    localparam logic [7:0] MONO_LEN     = 8'd56;
    localparam logic [7:0] MONO_HDE_ON  = 8'd1;
    localparam logic [7:0] MONO_HDE_OFF = 8'd40;
    localparam logic [7:0] MONO_HBL_ON  = 8'd44;
    localparam logic [7:0] MONO_HBL_OFF = 8'd3;
    localparam logic [7:0] MONO_HS_ON   = 8'd50;
    localparam logic [7:0] MONO_HS_OFF  = 8'd55;

    // Mono wins over NTSC, NTSC over PAL; nothing selected falls back to PAL.
    function automatic vmode_t decode_mode(input logic mde1, input logic cntsc, input logic cpal);
        vmode_t m;
        if (mde1) begin
            m = VM_MONO;
        end else if (cntsc) begin
            m = VM_NTSC;
        end else if (cpal) begin
            m = VM_PAL;
        end else begin
            m = VM_PAL;
        end
        return m;
    endfunction

    // Line length in slots for a mode; unknown encodings behave as PAL.
    function automatic logic [7:0] line_len(input vmode_t m);
        logic [7:0] len;
        case (m)
            VM_NTSC: len = NTSC_LEN;
            VM_MONO: len = MONO_LEN;
            default: len = PAL_LEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/hsyncgen_if.sv
// Slot enable, mode selects and decoded horizontal timing outputs.
interface hsyncgen_if #(
    parameter int HCNT_W = 7
);
    logic              cen;
    logic              mde1;
    logic              cpal;
    logic              cntsc;
    logic [HCNT_W-1:0] hcnt;
    logic              hde;
    logic              hblank;
    logic              ihsync;
    logic              line_start;

    modport slave (
        input  cen, mde1, cpal, cntsc,
        output hcnt, hde, hblank, ihsync, line_start
    );

    modport master (
        output cen, mde1, cpal, cntsc,
        input  hcnt, hde, hblank, ihsync, line_start
    );
endinterface

// File: rtl/hsyncgen_htim_decode.sv
// Pure combinational map from (slot count, mode) to horizontal events.
module htim_decode
    import vid_pkg::*;
#(
    parameter int HCNT_W = 7
) (
    input  logic [HCNT_W-1:0] i_hcnt,
    input  vmode_t            i_mode,
    output logic              o_hde,
    output logic              o_hblank,
    output logic              o_ihsync
);
    logic [7:0] w_h;
    logic [7:0] w_hde_on;
    logic [7:0] w_hde_off;
    logic [7:0] w_hbl_on;
    logic [7:0] w_hbl_off;
    logic [7:0] w_hs_on;
    logic [7:0] w_hs_off;

    assign w_h = 8'(i_hcnt);

    // Select the event table for the mode; hblank wraps around the line end.
    always_comb begin
        w_hde_on  = PAL_HDE_ON;
        w_hde_off = PAL_HDE_OFF;
        w_hbl_on  = PAL_HBL_ON;
        w_hbl_off = PAL_HBL_OFF;
        w_hs_on   = PAL_HS_ON;
        w_hs_off  = PAL_HS_OFF;
        case (i_mode)
            VM_NTSC: begin
                w_hde_on  = NTSC_HDE_ON;
                w_hde_off = NTSC_HDE_OFF;
                w_hbl_on  = NTSC_HBL_ON;
                w_hbl_off = NTSC_HBL_OFF;
                w_hs_on   = NTSC_HS_ON;
                w_hs_off  = NTSC_HS_OFF;
            end
            VM_MONO: begin
                w_hde_on  = MONO_HDE_ON;
                w_hde_off = MONO_HDE_OFF;
                w_hbl_on  = MONO_HBL_ON;
                w_hbl_off = MONO_HBL_OFF;
                w_hs_on   = MONO_HS_ON;
                w_hs_off  = MONO_HS_OFF;
            end
            default: begin
                w_hde_on  = PAL_HDE_ON;
                w_hde_off = PAL_HDE_OFF;
                w_hbl_on  = PAL_HBL_ON;
                w_hbl_off = PAL_HBL_OFF;
                w_hs_on   = PAL_HS_ON;
                w_hs_off  = PAL_HS_OFF;
            end
        endcase
        o_hde    = (w_h >= w_hde_on) && (w_h <= w_hde_off);
        o_hblank = (w_h >= w_hbl_on) || (w_h <= w_hbl_off);
        o_ihsync = (w_h >= w_hs_on)  && (w_h <= w_hs_off);
    end
endmodule

// File: rtl/hsyncgen.sv
// Horizontal timing generator: slot counter, per-line mode latch and
// registered horizontal events that always match the visible count.
module hsyncgen
    import vid_pkg::*;
#(
    parameter int HCNT_W = 7
) (
    input  logic        clk,
    input  logic        porb,
    hsyncgen_if.slave   vif
);
    logic [HCNT_W-1:0] r_hcnt;
    vmode_t            r_mode;
    logic              r_hde;
    logic              r_hblank;
    logic              r_ihsync;
    logic              r_line_start;

    logic              w_last;
    logic [HCNT_W-1:0] w_hcnt_next;
    vmode_t            w_mode_next;
    logic              w_hde;
    logic              w_hblank;
    logic              w_ihsync;

    // Next count and next mode; the mode only changes when the count wraps,
    // so a shorter line length can never strand the counter past its end.
    always_comb begin
        w_last      = (r_hcnt == HCNT_W'(line_len(r_mode) - 8'd1));
        w_hcnt_next = r_hcnt + HCNT_W'(1);
        w_mode_next = r_mode;
        if (w_last) begin
            w_hcnt_next = '0;
            w_mode_next = decode_mode(vif.mde1, vif.cntsc, vif.cpal);
        end else begin
            w_hcnt_next = r_hcnt + HCNT_W'(1);
            w_mode_next = r_mode;
        end
    end

    // Decode the upcoming count so registered outputs line up with hcnt.
    htim_decode #(.HCNT_W(HCNT_W)) u_decode (
        .i_hcnt   (w_hcnt_next),
        .i_mode   (w_mode_next),
        .o_hde    (w_hde),
        .o_hblank (w_hblank),
        .o_ihsync (w_ihsync)
    );

    // Counter, mode latch and output registers, advancing on slot enables.
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            r_hcnt       <= '0;
            r_mode       <= VM_PAL;
            r_hde        <= 1'b0;
            r_hblank     <= 1'b1;
            r_ihsync     <= 1'b0;
            r_line_start <= 1'b0;
        end else if (vif.cen) begin
            r_hcnt       <= w_hcnt_next;
            r_mode       <= w_mode_next;
            r_hde        <= w_hde;
            r_hblank     <= w_hblank;
            r_ihsync     <= w_ihsync;
            r_line_start <= w_last;
        end else begin
            r_line_start <= 1'b0;
        end
    end

    assign vif.hcnt       = r_hcnt;
    assign vif.hde        = r_hde;
    assign vif.hblank     = r_hblank;
    assign vif.ihsync     = r_ihsync;
    assign vif.line_start = r_line_start;
endmodule

// File: tb/tb_hsyncgen.sv
// Directed bench for hsyncgen: reset, PAL/NTSC/mono timing, cen gating.
module tb_hsyncgen;
    logic clk = 1'b0;
    logic porb;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Expected state: mode 0=PAL 1=NTSC 2=MONO
    int          e_hcnt;
    int          e_mode;
    logic        e_ls;
    logic [10:0] obs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hsyncgen_if #(.HCNT_W(7)) vif ();
    hsyncgen #(.HCNT_W(7)) dut (.clk(clk), .porb(porb), .vif(vif.slave));

    function automatic int len_of(input int m);
        case (m)
            1: return 127;
            2: return 56;
            default: return 128;
        endcase
    endfunction

    function automatic int sel_mode(input logic m1, input logic nt);
        if (m1) return 2;
        else if (nt) return 1;
        else return 0;
    endfunction

    function automatic logic [10:0] exp_vec(input int m, input int h, input logic ls);
        logic hde, hbl, hs;
        case (m)
            1: begin hde = (h >= 13 && h <= 92); hbl = (h >= 112 || h <= 23); hs = (h >= 117 && h <= 126); end
            2: begin hde = (h >= 1 && h <= 40);  hbl = (h >= 44 || h <= 3);   hs = (h >= 50 && h <= 55);   end
            default: begin hde = (h >= 14 && h <= 93); hbl = (h >= 113 || h <= 23); hs = (h >= 118 && h <= 127); end
        endcase
        return {7'(h), hde, hbl, hs, ls};
    endfunction

    // One slot: a single cen clk, sample just after it, then idle clocks.
    task automatic adv(input int gap);
        vif.cen = 1'b1;
        @(posedge clk); #1;
        vif.cen = 1'b0;
        obs = {vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start};
        if (e_hcnt == len_of(e_mode) - 1) begin
            e_hcnt = 0;
            e_mode = sel_mode(vif.mde1, vif.cntsc);
            e_ls   = 1'b1;
        end else begin
            e_hcnt++;
            e_ls = 1'b0;
        end
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        int first_ls_slot;
        int ls_cyc[$];
        porb = 1'b0; vif.cen = 1'b0; vif.mde1 = 1'b0; vif.cpal = 1'b0; vif.cntsc = 1'b0;
        e_hcnt = 0; e_mode = 0; e_ls = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start} !== 11'b0000000_0_1_0_0) begin
            failures++; $display("FAIL reset_state got=%b want=%b", {vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start}, 11'b00000000100);
        end
        porb = 1'b1;
        for (int i = 0; i < 70; i++) adv(4);
        checks++;
        if (obs !== exp_vec(e_mode, e_hcnt, e_ls) || vif.hcnt !== 7'd70) begin
            failures++; $display("FAIL pre_reset_hcnt70 got=%b want=%b", obs, exp_vec(e_mode, e_hcnt, e_ls));
        end
        porb = 1'b0; #1;
        checks++;
        if ({vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start} !== 11'b0000000_0_1_0_0) begin
            failures++; $display("FAIL midline_reset got=%b want=%b", {vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start}, 11'b00000000100);
        end
        @(posedge clk); #1;
        porb = 1'b1; e_hcnt = 0; e_mode = 0; e_ls = 1'b0;
        first_ls_slot = -1;
        for (int i = 1; i <= 256; i++) begin
            adv(16);
            checks++;
            if (obs !== exp_vec(e_mode, e_hcnt, e_ls)) begin
                failures++; $display("FAIL pal_idle slot=%0d got=%b want=%b", i, obs, exp_vec(e_mode, e_hcnt, e_ls));
            end
            if (obs[0]) begin
                ls_cyc.push_back(cyc);
                if (first_ls_slot < 0) first_ls_slot = i;
            end
        end
        checks++;
        if (first_ls_slot != 128) begin
            failures++; $display("FAIL first_wrap_slot got=%0d want=128", first_ls_slot);
        end
        checks++;
        if (ls_cyc.size() != 2 || (ls_cyc.size() == 2 && ls_cyc[1] - ls_cyc[0] != 2048)) begin
            failures++; $display("FAIL line_start_period pulses=%0d want=2 spacing_clk=2048", ls_cyc.size());
        end
    endtask

    task automatic test_pal_decode();
        int rise, fall, hs_cnt;
        rise = -1; fall = -1; hs_cnt = 0;
        vif.cpal = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic prev_hde;
            prev_hde = obs[3];
            adv(4);
            checks++;
            if (obs !== exp_vec(e_mode, e_hcnt, e_ls)) begin
                failures++; $display("FAIL pal_decode slot=%0d got=%b want=%b", i, obs, exp_vec(e_mode, e_hcnt, e_ls));
            end
            if (!prev_hde && obs[3] && rise < 0) rise = int'(obs[10:4]);
            if (prev_hde && !obs[3] && fall < 0) fall = int'(obs[10:4]);
            if (obs[1]) hs_cnt++;
        end
        checks++;
        if (rise != 14 || fall != 94) begin
            failures++; $display("FAIL pal_hde_edges rise=%0d fall=%0d want 14/94", rise, fall);
        end
        checks++;
        if (hs_cnt != 20) begin
            failures++; $display("FAIL pal_ihsync_width got=%0d want=20", hs_cnt);
        end
    endtask

    task automatic test_ntsc_switch();
        int ls_slot, hs_first, hs_cnt;
        for (int i = 0; i < 60; i++) adv(4);
        vif.cntsc = 1'b1;
        ls_slot = -1;
        for (int i = 61; i <= 128; i++) begin
            adv(4);
            if (obs[0] && ls_slot < 0) ls_slot = i;
        end
        checks++;
        if (ls_slot != 128) begin
            failures++; $display("FAIL ntsc_switch_line_len got=%0d want=128", ls_slot);
        end
        ls_slot = -1; hs_first = -1; hs_cnt = 0;
        for (int i = 1; i <= 127; i++) begin
            adv(4);
            checks++;
            if (obs !== exp_vec(1, e_hcnt, e_ls)) begin
                failures++; $display("FAIL ntsc_decode slot=%0d got=%b want=%b", i, obs, exp_vec(1, e_hcnt, e_ls));
            end
            if (obs[0] && ls_slot < 0) ls_slot = i;
            if (obs[1]) begin hs_cnt++; if (hs_first < 0) hs_first = int'(obs[10:4]); end
        end
        checks++;
        if (ls_slot != 127 || hs_first != 117 || hs_cnt != 10) begin
            failures++; $display("FAIL ntsc_line len=%0d hs_first=%0d hs_cnt=%0d want 127/117/10", ls_slot, hs_first, hs_cnt);
        end
    endtask

    task automatic test_mono_priority();
        int falls, pulses;
        logic prev_hs;
        vif.mde1 = 1'b1; vif.cpal = 1'b1; vif.cntsc = 1'b0;
        for (int i = 0; i < 127; i++) adv(4);
        falls = 0; pulses = 0; prev_hs = obs[1];
        for (int i = 1; i <= 560; i++) begin
            adv(4);
            checks++;
            if (obs !== exp_vec(2, e_hcnt, e_ls)) begin
                failures++; $display("FAIL mono_decode slot=%0d got=%b want=%b", i, obs, exp_vec(2, e_hcnt, e_ls));
            end
            if (prev_hs && !obs[1]) falls++;
            if (obs[0]) pulses++;
            prev_hs = obs[1];
        end
        checks++;
        if (falls != 10 || pulses != 10) begin
            failures++; $display("FAIL mono_counts falls=%0d lines=%0d want 10/10", falls, pulses);
        end
    endtask

    task automatic test_cen_gating();
        int guard;
        vif.mde1 = 1'b0; vif.cpal = 1'b0; vif.cntsc = 1'b0;
        guard = 0;
        while (!(e_mode == 0 && e_hcnt == 117) && guard < 400) begin adv(2); guard++; end
        checks++;
        if (guard >= 400 || obs !== exp_vec(0, 117, 1'b0)) begin
            failures++; $display("FAIL reach_hcnt117 got=%b want=%b", obs, exp_vec(0, 117, 1'b0));
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start} !== exp_vec(0, 117, 1'b0)) begin
                failures++; $display("FAIL cen_hold clk=%0d got=%b want=%b", i, {vif.hcnt, vif.hde, vif.hblank, vif.ihsync, vif.line_start}, exp_vec(0, 117, 1'b0));
            end
        end
        adv(4);
        checks++;
        if (obs !== exp_vec(0, 118, 1'b0)) begin
            failures++; $display("FAIL cen_resume got=%b want=%b", obs, exp_vec(0, 118, 1'b0));
        end
        adv(4); adv(4);
        porb = 1'b0; #1;
        checks++;
        if ({vif.hcnt, vif.ihsync, vif.hblank} !== {7'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL reset_in_hsync got hcnt=%0d ihsync=%b hblank=%b want 0/0/1", vif.hcnt, vif.ihsync, vif.hblank);
        end
        @(posedge clk); #1;
        porb = 1'b1; e_hcnt = 0; e_mode = 0; e_ls = 1'b0;
    endtask

    task automatic test_no_mode();
        int ls_slots[$];
        for (int i = 1; i <= 256; i++) begin
            adv(2);
            checks++;
            if (obs !== exp_vec(0, e_hcnt, e_ls)) begin
                failures++; $display("FAIL no_mode slot=%0d got=%b want=%b", i, obs, exp_vec(0, e_hcnt, e_ls));
            end
            if (obs[0]) ls_slots.push_back(i);
        end
        checks++;
        if (ls_slots.size() != 2 || (ls_slots.size() == 2 && (ls_slots[0] != 128 || ls_slots[1] != 256))) begin
            failures++; $display("FAIL no_mode_line_len wraps=%0d want 2 at 128/256", ls_slots.size());
        end
    endtask

    initial begin
        test_reset();
        test_pal_decode();
        test_ntsc_switch();
        test_mono_priority();
        test_cen_gating();
        test_no_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
